instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
- Next-generation MIPS instruction memory: synchronous, parametrised in data width, depth and address width, with a registered fetch port and a program-load port.
- Sits between the PC/fetch stage and decode.
- Replaces combinational instruction lookup with a one-cycle-latency, stallable, pipelined fetch.
- Adds a program-load write port, fault reporting for bad addresses, and an optional post-reset clear sequence.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 256, number of instruction words; need not be a power of two.
- ADDR_W, 32, width of the byte addresses on fetch and load ports.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- fetch_req  input  1  fetch request for fetch_addr.
- fetch_addr  input  ADDR_W  byte address of the instruction.
- fetch_ready  output  1  block can accept a fetch this cycle.
- instr_out  output  DATA_W  fetched instruction word (registered).
- instr_valid  output  1  instr_out holds a valid response.
- fetch_fault  output  1  the current response came from a misaligned or out-of-range address.
- instr_stall  input  1  consumer cannot take the current response; hold it.
- load_en  input  1  write load_data to load_addr this cycle.
- load_addr  input  ADDR_W  byte address for the program write.
- load_data  input  DATA_W  instruction word to write.
- init_busy  output  1  clear sequence in progress (tied 0 without the optional feature).

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Addressing:
  - Word index = addr[IDX_W+1:2], where IDX_W = clog2(DEPTH).
  - An address is bad if addr[1:0] != 0, or if addr[ADDR_W-1:2] >= DEPTH (upper bits included in the compare).
- Reset values: instr_out=0, instr_valid=0, fetch_fault=0. Memory contents are not touched by reset except through the optional feature.
- fetch_ready = !(instr_valid && instr_stall) && state != S_CLEAR. It is combinational from state and outputs only, never from fetch_req.
- Accept = fetch_req && fetch_ready. Response is registered on the next edge:
  - instr_valid=1.
  - Good address: instr_out = mem[index], fetch_fault=0.
  - Bad address: instr_out = 0 (NOP), fetch_fault=1.
- Latency is exactly 1 cycle. Back-to-back accepts give one response per cycle.
- No accept while not stalled: instr_valid drops to 0 on the next edge; instr_out holds its last value.
- instr_valid && instr_stall: instr_out, instr_valid and fetch_fault hold unchanged, and no accept occurs. The stall releases on the first cycle instr_stall=0.
- Load:
  - load_en on a good load_addr writes mem[index] at the edge.
  - A bad load_addr is silently dropped.
  - Loads are accepted regardless of fetch state, except during S_CLEAR, when they are dropped.
- Same-cycle load and accepted fetch to the same word: the fetch returns the old data (read-before-write). The next fetch sees the new data.
- FSM, states S_CLEAR and S_RUN:
  - Without the optional feature, the state is always S_RUN.
  - S_CLEAR -> S_RUN after the word DEPTH-1 has been written.
- rst_n low at any time, including mid-clear or mid-stall: outputs return to reset values, and the clear counter restarts at 0 on the first cycle after release.

Optional Feature:
- Macro: INSTR_MEM_INIT_CLEAR_EN.
- Defined:
  - After reset release, the FSM enters S_CLEAR.
  - A counter writes 0 to words 0..DEPTH-1, one per cycle. This takes exactly DEPTH cycles.
  - init_busy=1 and fetch_ready=0 throughout; loads are ignored.
  - The cycle after word DEPTH-1 is written: S_RUN, init_busy=0, fetch_ready=1.
- Undefined:
  - No counter; the block starts in S_RUN and init_busy is tied to 0.
  - fetch_ready=1 on the first cycle after reset.
  - Memory is uninitialised unless it is loaded first.

Decomposition:
- Package instr_mem_pkg holds:
  - state enum {S_CLEAR, S_RUN};
  - NOP_WORD = 0;
  - a helper function for the address-valid check (alignment plus range);
  - an index-width localparam derived with clog2.
- One sub-module, instr_mem_array: storage with one synchronous read port, one write port and read-before-write semantics. The top level holds the FSM, clear counter, handshake and fault logic.

Test Plan:
- Load 0x20020005 at addr 0x0 and 0x2003000C at addr 0x4. Fetch 0x0 then 0x4 in back-to-back cycles -> instr_out=0x20020005 then 0x2003000C on consecutive cycles, instr_valid=1, fetch_fault=0.
- Fetch 0x6 (misaligned), then 0x400 with DEPTH=256 (out of range) -> instr_out=0, fetch_fault=1 for each, one cycle after accept.
- Response 0x2067FFF7 valid, hold instr_stall=1 for 3 cycles with fetch_req=1 -> fetch_ready=0, output stable all 3 cycles. Release -> the next address is accepted in that cycle.
- Word 0x8 = 0x00E22025; load 0xDEADBEEF at 0x8 in the same cycle as fetch 0x8 -> response 0x00E22025. Fetch 0x8 again -> 0xDEADBEEF.
- With INSTR_MEM_INIT_CLEAR_EN and DEPTH=16 -> init_busy=1 for exactly 16 cycles after reset, a load issued during clear is dropped, and fetches of any address return 0.
- Assert rst_n=0 mid-clear (cycle 5) and mid-stall -> outputs go to reset values on that edge, and the clear restarts from word 0 (full 16 cycles).

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Contents: FSM state enum, NOP word, index-width helper, address-valid check.
package instr_mem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam int unsigned NOP_WORD      = 0;
  localparam int unsigned DEFAULT_DEPTH = 256;

  // Word-index width; a single-word memory still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DEFAULT_IDX_W = idx_width(DEFAULT_DEPTH);

  // Word aligned and word number below depth; all upper address bits take part.
  function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous read port, one write port.
// A read and a write to the same word in one cycle return the old word.
// Ports: clk, rst_n (sync, clears read register only), rd_en/rd_zero/rd_idx ->
// rd_data (registered, holds when rd_en=0), wr_en/wr_idx/wr_data.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned IDX_W  = DEFAULT_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Registered read; rd_zero substitutes the NOP word for rejected addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? DATA_W'(NOP_WORD) : mem[rd_idx];
    end
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous MIPS instruction memory with stallable one-cycle fetch and a
// program-load port. Optional post-reset clear: define INSTR_MEM_INIT_CLEAR_EN.
// Ports: clk, rst_n (sync active-low); fetch_req/fetch_addr -> fetch_ready,
// instr_out/instr_valid/fetch_fault with instr_stall backpressure;
// load_en/load_addr/load_data program write; init_busy clear in progress.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              fetch_fault,
  input  logic              instr_stall,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              init_busy
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_t            state, state_next;
  logic              fetch_ok, load_ok, accept;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign fetch_ok = addr_ok(64'(fetch_addr), DEPTH);
  assign load_ok  = addr_ok(64'(load_addr), DEPTH);

  // Ready depends only on state and held response, never on fetch_req.
  assign fetch_ready = !(instr_valid && instr_stall) && (state == S_RUN);
  assign accept      = fetch_req && fetch_ready;

`ifdef INSTR_MEM_INIT_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt, clr_cnt_next;

  // State, clear counter and busy flag; reset restarts the clear at word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      init_busy <= (state_next == S_CLEAR);
    end
  end
`else
  // Without the clear sequence the block only ever runs.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_next;
  end

  assign init_busy = 1'b0;
`endif

  // Next state and write-port steering: clear writes own the port in S_CLEAR.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_idx     = load_addr[IDX_W+1:2];
    wr_data    = load_data;
`ifdef INSTR_MEM_INIT_CLEAR_EN
    clr_cnt_next = clr_cnt;
`endif
    case (state)
      S_CLEAR: begin
`ifdef INSTR_MEM_INIT_CLEAR_EN
        wr_en   = 1'b1;
        wr_idx  = clr_cnt;
        wr_data = DATA_W'(NOP_WORD);
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_next = S_RUN;
        else                              clr_cnt_next = clr_cnt + IDX_W'(1);
`else
        state_next = S_RUN;
`endif
      end
      default: wr_en = load_en && load_ok;
    endcase
  end

  // Response handshake: capture on accept, hold under stall, else drop valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (accept) begin
      instr_valid <= 1'b1;
      fetch_fault <= !fetch_ok;
    end else if (!(instr_valid && instr_stall)) begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (accept),
    .rd_zero (!fetch_ok),
    .rd_idx  (fetch_addr[IDX_W+1:2]),
    .rd_data (instr_out),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: reference memory model plus a
// response queue filled at accept time and drained when the response appears.
module tb_instr_mem_sync;

`ifdef INSTR_MEM_INIT_CLEAR_EN
  localparam int unsigned DEPTH     = 16;
  localparam bit          HAS_CLEAR = 1'b1;
`else
  localparam int unsigned DEPTH     = 256;
  localparam bit          HAS_CLEAR = 1'b0;
`endif
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_fault;
  logic        instr_stall;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        init_busy;

  instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .instr_out(instr_out), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault), .instr_stall(instr_stall), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_valid;
  int          m_clear_left;
  int          checks = 0;
  int          passes = 0;

  function automatic bit good(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  // One clock of stimulus; updates the model and queues the expected response.
  task automatic drive(input logic req, input logic [31:0] fa, input logic stall,
                       input logic ld, input logic [31:0] la, input logic [31:0] ldv,
                       output logic rdy, output bit acc);
    exp_t e;
    fetch_req = req; fetch_addr = fa; instr_stall = stall;
    load_en = ld; load_addr = la; load_data = ldv;
    #1 rdy = fetch_ready;
    acc = rst_n && req && !(m_valid && stall) && (m_clear_left == 0);
    if (acc) begin
      e.fault = !good(fa);
      e.data  = good(fa) ? m_mem[fa[IDX_W+1:2]] : 32'h0;
      sbq.push_back(e);
    end
    if (rst_n && ld && good(la) && m_clear_left == 0) m_mem[la[IDX_W+1:2]] = ldv;
    @(posedge clk); #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_clear_left = HAS_CLEAR ? DEPTH : 0; sbq.delete();
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end else if (acc) begin
      m_valid = 1'b1;
    end else if (!(m_valid && stall)) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    logic r; bit a;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, r, a);
  endtask

  // Fetch one address and compare the response against the queue head.
  task automatic test_fetch(input string name, input logic [31:0] fa,
                            input logic ld, input logic [31:0] la, input logic [31:0] ldv);
    logic r; bit a; exp_t e;
    drive(1, fa, 0, ld, la, ldv, r, a);
    checks++;
    if (!a || sbq.size() == 0) begin
      $display("FAIL %s: fetch not accepted (ready=%b)", name, r);
    end else begin
      e = sbq.pop_front();
      if ({instr_valid, fetch_fault, instr_out} !== {1'b1, e.fault, e.data})
        $display("FAIL %s: got v=%b f=%b d=%h want v=1 f=%b d=%h",
                 name, instr_valid, fetch_fault, instr_out, e.fault, e.data);
      else passes++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    checks++;
    if ({instr_valid, fetch_fault, instr_out} !== 34'h0)
      $display("FAIL reset_outputs: got v=%b f=%b d=%h want 0", instr_valid, fetch_fault, instr_out);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({fetch_ready, init_busy} !== {!HAS_CLEAR, HAS_CLEAR})
      $display("FAIL reset_ready: got ready=%b busy=%b want ready=%b busy=%b",
               fetch_ready, init_busy, !HAS_CLEAR, HAS_CLEAR);
    else passes++;
  endtask

  task automatic test_load_fetch;
    logic r; bit a;
    drive(0, 0, 0, 1, 32'h0, 32'h20020005, r, a);
    drive(0, 0, 0, 1, 32'h4, 32'h2003000C, r, a);
    test_fetch("b2b_0", 32'h0, 0, 0, 0);
    test_fetch("b2b_4", 32'h4, 0, 0, 0);
    idle(1);
    checks++;
    if ({instr_valid, instr_out} !== {1'b0, 32'h2003000C})
      $display("FAIL idle_hold: got v=%b d=%h want v=0 d=2003000c", instr_valid, instr_out);
    else passes++;
    drive(0, 0, 0, 1, (DEPTH - 1) * 4, 32'h12345678, r, a);
    test_fetch("last_word", (DEPTH - 1) * 4, 0, 0, 0);
  endtask

  task automatic test_fault;
    logic r; bit a;
    test_fetch("misaligned", 32'h6, 0, 0, 0);
    test_fetch("out_of_range", DEPTH * 4, 0, 0, 0);
    test_fetch("upper_bits", 32'h8000_0000, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h14, 32'h0BADF00D, r, a);
    drive(0, 0, 0, 1, 32'h16, 32'hFFFFFFFF, r, a);
    test_fetch("bad_load_dropped", 32'h14, 0, 0, 0);
  endtask

  task automatic test_stall;
    logic r; bit a;
    int bad = 0;
    drive(0, 0, 0, 1, 32'hC, 32'h2067FFF7, r, a);
    test_fetch("stall_setup", 32'hC, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0, 1, 0, 0, 0, r, a);
      if (r !== 1'b0 || {instr_valid, fetch_fault, instr_out} !== {1'b1, 1'b0, 32'h2067FFF7}) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL stall_hold: %0d bad cycles, want 0", bad);
    else passes++;
    test_fetch("stall_release", 32'h0, 0, 0, 0);
  endtask

  task automatic test_rbw;
    logic r; bit a;
    drive(0, 0, 0, 1, 32'h8, 32'h00E22025, r, a);
    test_fetch("rbw_old", 32'h8, 1, 32'h8, 32'hDEADBEEF);
    test_fetch("rbw_new", 32'h8, 0, 0, 0);
  endtask

  // Counts init_busy cycles from the current point, bounded.
  task automatic count_clear(input string name, input bit do_load);
    logic r; bit a;
    int n = 0, rdy_bad = 0;
    while (init_busy === 1'b1 && n < 100) begin
      drive(0, 0, 0, do_load && n == 3, 32'h0, 32'hFFFFFFFF, r, a);
      if (r !== 1'b0) rdy_bad++;
      n++;
    end
    checks++;
    if (n != DEPTH || rdy_bad != 0)
      $display("FAIL %s: busy cycles=%0d ready_high=%0d want %0d and 0", name, n, rdy_bad, DEPTH);
    else passes++;
  endtask

  task automatic test_clear;
    count_clear("clear_len", 1'b1);
    test_fetch("clear_w0", 32'h0, 0, 0, 0);
    test_fetch("clear_wlast", (DEPTH - 1) * 4, 0, 0, 0);
    test_fetch("clear_oob", DEPTH * 4, 0, 0, 0);
  endtask

  task automatic test_reset_mid_clear;
    logic r; bit a;
    drive(0, 0, 0, 1, 32'h0, 32'h55555555, r, a);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    idle(5);
    rst_n = 1'b0; idle(1);
    checks++;
    if ({instr_valid, fetch_fault, instr_out, init_busy} !== {34'h0, 1'b1})
      $display("FAIL midclear_reset: got v=%b f=%b d=%h busy=%b", instr_valid, fetch_fault, instr_out, init_busy);
    else passes++;
    rst_n = 1'b1;
    count_clear("clear_restart", 1'b0);
    test_fetch("restart_w0", 32'h0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_stall;
    logic r; bit a;
    test_fetch("rs_setup", 32'h4, 0, 0, 0);
    drive(1, 32'h0, 1, 0, 0, 0, r, a);
    rst_n = 1'b0;
    drive(1, 32'h0, 1, 0, 0, 0, r, a);
    checks++;
    if ({instr_valid, fetch_fault, instr_out} !== 34'h0)
      $display("FAIL midstall_reset: got v=%b f=%b d=%h want 0", instr_valid, fetch_fault, instr_out);
    else passes++;
    rst_n = 1'b1;
    for (int i = 0; i < 100 && m_clear_left > 0; i++) idle(1);
    test_fetch("post_reset_fetch", 32'h8, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    m_valid = 1'b0; m_clear_left = 0;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; instr_stall = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(posedge clk); #1;
    test_reset();
    if (HAS_CLEAR) begin
      test_clear();
      test_reset_mid_clear();
    end
    test_load_fetch();
    test_fault();
    test_stall();
    test_rbw();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
